// File: rtl/sega_joy_pkg.sv
// Shared constants and types for the DB9 Sega/Atari joystick reader:
// button bit positions, pin positions, poll-frame states and the select-line schedule.
package sega_joy_pkg;

  typedef logic [11:0] joy_vec_t;

  // Output vector layout {M, X, Y, Z, S, A, C, B, R, L, D, U}
  localparam int JOY_U = 0;
  localparam int JOY_D = 1;
  localparam int JOY_L = 2;
  localparam int JOY_R = 3;
  localparam int JOY_B = 4;
  localparam int JOY_C = 5;
  localparam int JOY_A = 6;
  localparam int JOY_S = 7;
  localparam int JOY_Z = 8;
  localparam int JOY_Y = 9;
  localparam int JOY_X = 10;
  localparam int JOY_M = 11;

  // Raw pin bus layout {p9, p6, right, left, down, up}
  localparam int PIN_U  = 0;
  localparam int PIN_D  = 1;
  localparam int PIN_L  = 2;
  localparam int PIN_R  = 3;
  localparam int PIN_P6 = 4;
  localparam int PIN_P9 = 5;

  localparam logic [7:0] ST0 = 8'd0;
  localparam logic [7:0] ST1 = 8'd1;
  localparam logic [7:0] ST2 = 8'd2;
  localparam logic [7:0] ST3 = 8'd3;
  localparam logic [7:0] ST4 = 8'd4;
  localparam logic [7:0] ST5 = 8'd5;
  localparam logic [7:0] ST6 = 8'd6;

  // Select level driven after the tick that leaves state st; idle states hold it high.
  function automatic logic p7_after(input logic [7:0] st);
    logic lvl;
    lvl = 1'b1;
    if (st == ST0 || st == ST2 || st == ST4 || st == ST6) lvl = 1'b0;
    return lvl;
  endfunction

endpackage

// File: rtl/sega_port_decode.sv
// Per-port decoder: samples one synchronised DB9 pin bus at the poll-frame ticks,
// builds the button shadow and publishes it to the outputs at the commit tick.
module sega_port_decode
  import sega_joy_pkg::*;
(
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       tick_i,
  input  logic [7:0] st_i,
  input  logic [5:0] pins_i,
  output joy_vec_t   joy_o,
  output logic       six_o
);

  joy_vec_t shadow_q, shadow_d;
  joy_vec_t joy_q, joy_d;
  logic     six_sh_q, six_sh_d;
  logic     six_q, six_d;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves it unassigned (no latch).
    shadow_d = shadow_q;
    six_sh_d = six_sh_q;
    joy_d    = joy_q;
    six_d    = six_q;
    if (tick_i) begin
      unique case (st_i)
        ST2: begin
          shadow_d[JOY_R:JOY_U] = pins_i[PIN_R:PIN_U];
          shadow_d[JOY_C:JOY_B] = pins_i[PIN_P9:PIN_P6];
          six_sh_d              = 1'b0;
        end
        ST3: begin
          // R and L both low while select is low only happens on a Mega Drive pad.
          if (!pins_i[PIN_R] && !pins_i[PIN_L])
            shadow_d[JOY_S:JOY_A] = pins_i[PIN_P9:PIN_P6];
          else
            shadow_d[JOY_S:JOY_B] = {2'b11, pins_i[PIN_P9:PIN_P6]};
        end
        ST5: begin
          if (pins_i[PIN_R:PIN_U] == 4'h0) six_sh_d = 1'b1;
        end
        ST6: begin
          shadow_d[JOY_M:JOY_Z] = six_sh_q ? pins_i[PIN_R:PIN_U] : 4'hF;
          joy_d                 = shadow_d;
          six_d                 = six_sh_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the shadow is a plain register, so it takes the async reset like the rest of the state.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      shadow_q <= '1;
      six_sh_q <= 1'b0;
      joy_q    <= '1;
      six_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      six_sh_q <= six_sh_d;
      joy_q    <= joy_d;
      six_q    <= six_d;
    end
  end

  assign joy_o = joy_q;
  assign six_o = six_q;

endmodule

// File: rtl/sega_joy_reader.sv
// Two-port DB9 joystick reader: synchronises the pins, runs the tick-paced poll
// frame, drives the shared select line and decodes both ports.
module sega_joy_reader
  import sega_joy_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = 256
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       tick_i,
  input  logic [5:0] joy1_pins_i,
  input  logic [5:0] joy2_pins_i,
  output logic       p7_o,
  output joy_vec_t   joy1_o,
  output joy_vec_t   joy2_o,
  output logic       six1_o,
  output logic       six2_o,
  output logic       valid_o
);

  localparam logic [7:0] ST_LAST = 8'(FRAME_TICKS - 1);

  logic [5:0] s1_meta_q, s1_q;
  logic [5:0] s2_meta_q, s2_q;
  logic [7:0] st_q, st_d;
  logic       p7_q, p7_d;
  logic       valid_q, valid_d;

  always_comb begin
    st_d    = st_q;
    p7_d    = p7_q;
    valid_d = tick_i && (st_q == ST6);
    if (tick_i) begin
      st_d = (st_q == ST_LAST) ? ST0 : st_q + 8'd1;
      p7_d = p7_after(st_q);
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      s1_meta_q <= '1;
      s1_q      <= '1;
      s2_meta_q <= '1;
      s2_q      <= '1;
      st_q      <= ST0;
      p7_q      <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      s1_meta_q <= joy1_pins_i;
      s1_q      <= s1_meta_q;
      s2_meta_q <= joy2_pins_i;
      s2_q      <= s2_meta_q;
      st_q      <= st_d;
      p7_q      <= p7_d;
      valid_q   <= valid_d;
    end
  end

  sega_port_decode u_port1 (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .tick_i  (tick_i),
    .st_i    (st_q),
    .pins_i  (s1_q),
    .joy_o   (joy1_o),
    .six_o   (six1_o)
  );

  sega_port_decode u_port2 (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .tick_i  (tick_i),
    .st_i    (st_q),
    .pins_i  (s2_q),
    .joy_o   (joy2_o),
    .six_o   (six2_o)
  );

  assign p7_o    = p7_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_sega_joy_reader.sv
// Directed bench for sega_joy_reader: behavioural 2/3/6-button pad models on both
// ports, expected frames queued when stimulus is set and popped at each valid pulse.
module tb_sega_joy_reader;
  import sega_joy_pkg::*;

  typedef enum int {PAD_NONE, PAD_TWO, PAD_THREE, PAD_SIX} pad_e;
  typedef struct {
    joy_vec_t j1;
    joy_vec_t j2;
    logic     s1;
    logic     s2;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       res_n_i = 1'b0;
  logic       tick_i = 1'b0;
  logic [5:0] joy1_pins_i, joy2_pins_i;
  logic       p7_o, six1_o, six2_o, valid_o;
  joy_vec_t   joy1_o, joy2_o;

  pad_e     kind1 = PAD_NONE, kind2 = PAD_NONE;
  joy_vec_t btn1 = 12'hFFF, btn2 = 12'hFFF;
  int       low_cnt = 0, idle_cnt = 0;
  logic     p7_prev = 1'b1;
  longint   cyc = 0;
  int       n_assert = 0, n_fail = 0;
  exp_t     exp_q[$];

  sega_joy_reader #(.FRAME_TICKS(256)) dut (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .tick_i      (tick_i),
    .joy1_pins_i (joy1_pins_i),
    .joy2_pins_i (joy2_pins_i),
    .p7_o        (p7_o),
    .joy1_o      (joy1_o),
    .joy2_o      (joy2_o),
    .six1_o      (six1_o),
    .six2_o      (six2_o),
    .valid_o     (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // One tick every 8 clocks, high for exactly one rising edge.
  initial begin
    forever begin
      repeat (7) @(posedge clk_i);
      #1 tick_i = 1'b1;
      @(posedge clk_i);
      #1 tick_i = 1'b0;
    end
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  // Pad phase counter: counts select falling edges, cleared after a long high idle.
  always @(posedge clk_i) begin
    p7_prev <= p7_o;
    if (p7_prev && !p7_o) low_cnt <= low_cnt + 1;
    if (p7_o) begin
      if (idle_cnt > 100) low_cnt <= 0;
      idle_cnt <= idle_cnt + 1;
    end else begin
      idle_cnt <= 0;
    end
  end

  function automatic logic [5:0] pad_pins(input pad_e kind, input joy_vec_t b,
                                          input logic p7, input int cnt);
    logic [5:0] p;
    p = 6'h3F;
    case (kind)
      PAD_TWO:   p = {b[JOY_C], b[JOY_B], b[JOY_R], b[JOY_L], b[JOY_D], b[JOY_U]};
      PAD_THREE: p = p7 ? {b[JOY_C], b[JOY_B], b[JOY_R], b[JOY_L], b[JOY_D], b[JOY_U]}
                        : {b[JOY_S], b[JOY_A], 2'b00, b[JOY_D], b[JOY_U]};
      PAD_SIX: begin
        if (p7)
          p = (cnt == 3) ? {b[JOY_C], b[JOY_B], b[JOY_M], b[JOY_X], b[JOY_Y], b[JOY_Z]}
                         : {b[JOY_C], b[JOY_B], b[JOY_R], b[JOY_L], b[JOY_D], b[JOY_U]};
        else if (cnt == 3)
          p = {b[JOY_S], b[JOY_A], 4'h0};
        else if (cnt == 4)
          p = {b[JOY_S], b[JOY_A], 4'hF};
        else
          p = {b[JOY_S], b[JOY_A], 2'b00, b[JOY_D], b[JOY_U]};
      end
      default: p = 6'h3F;
    endcase
    return p;
  endfunction

  always_comb begin
    joy1_pins_i = pad_pins(kind1, btn1, p7_o, low_cnt);
    joy2_pins_i = pad_pins(kind2, btn2, p7_o, low_cnt);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_frame(input joy_vec_t j1, input joy_vec_t j2,
                              input logic s1, input logic s2);
    exp_t e;
    e.j1 = j1; e.j2 = j2; e.s1 = s1; e.s2 = s2;
    exp_q.push_back(e);
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    check({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_joy1"}, 32'(joy1_o), 32'(e.j1));
      check({tag, "_joy2"}, 32'(joy2_o), 32'(e.j2));
      check({tag, "_six1"}, 32'(six1_o), 32'(e.s1));
      check({tag, "_six2"}, 32'(six2_o), 32'(e.s2));
    end
  endtask

  task automatic wait_commit(input string tag, output longint stamp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen = 1'b1;
    end
    stamp = cyc;
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      compare_head(tag);
      @(negedge clk_i);
      check({tag, "_valid_one_cycle"}, 32'(valid_o), 32'd0);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk_i); while (tick_i !== 1'b1);
    end
  endtask

  initial begin
    longint t0, t1, t2;
    bit     seen;

    repeat (3) @(negedge clk_i);
    check("rst_p7",    32'(p7_o),    32'd1);
    check("rst_joy1",  32'(joy1_o),  32'hFFF);
    check("rst_joy2",  32'(joy2_o),  32'hFFF);
    check("rst_six1",  32'(six1_o),  32'd0);
    check("rst_six2",  32'(six2_o),  32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    res_n_i = 1'b1;

    // Idle pins: three frames, commits spaced by 256 ticks of 8 clocks.
    repeat (3) expect_frame(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    wait_commit("idle_f1", t0);
    wait_commit("idle_f2", t1);
    wait_commit("idle_f3", t2);
    check("idle_spacing_12", 32'(t1 - t0), 32'd2048);
    check("idle_spacing_23", 32'(t2 - t1), 32'd2048);

    // 3-button pad on port 1 with Start and B pressed.
    kind1 = PAD_THREE; btn1 = 12'hF6F;
    expect_frame(12'hF6F, 12'hFFF, 1'b0, 1'b0);
    wait_commit("three_sb", t0);

    // 6-button X+Up on port 1, 2-button fire+Left on port 2.
    kind1 = PAD_SIX; btn1 = 12'hBFE;
    kind2 = PAD_TWO; btn2 = 12'hFEB;
    expect_frame(12'hBFE, 12'hFEB, 1'b1, 1'b0);
    wait_commit("six_p1_two_p2", t0);

    // Swap: 2-button on port 1, 6-button on port 2.
    kind1 = PAD_TWO; btn1 = 12'hFEB;
    kind2 = PAD_SIX; btn2 = 12'hBFE;
    expect_frame(12'hFEB, 12'hBFE, 1'b0, 1'b1);
    wait_commit("two_p1_six_p2", t0);

    kind1 = PAD_SIX; btn1 = 12'hBFE;
    kind2 = PAD_NONE; btn2 = 12'hFFF;
    expect_frame(12'hBFE, 12'hFFF, 1'b1, 1'b0);
    wait_commit("six_p1", t0);

    // Press Mode right after the ST2 tick; outputs must hold until the commit.
    wait_ticks(252);
    btn1 = 12'h3FE;
    expect_frame(12'h3FE, 12'hFFF, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen = 1'b1;
      else check("mode_hold_joy1", 32'(joy1_o), 32'hBFE);
    end
    check("mode_valid_seen", 32'(seen), 32'd1);
    if (seen) compare_head("mode_commit");
    @(negedge clk_i);

    // Asynchronous reset in ST4, between clock edges.
    wait_ticks(253);
    @(negedge clk_i);
    check("pre_rst_joy1", 32'(joy1_o), 32'h3FE);
    #2 res_n_i = 1'b0;
    #1;
    check("arst_p7",    32'(p7_o),    32'd1);
    check("arst_joy1",  32'(joy1_o),  32'hFFF);
    check("arst_joy2",  32'(joy2_o),  32'hFFF);
    check("arst_six1",  32'(six1_o),  32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    repeat (200) @(negedge clk_i);
    res_n_i = 1'b1;
    expect_frame(12'h3FE, 12'hFFF, 1'b1, 1'b0);
    wait_commit("post_rst", t0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
